// File: rtl/q2_control.sv
// Q2 central sequencer: fetches instructions over a req/ack handshake, decodes
// the 3-bit opcode and issues one-cycle strobes to the slice array. It also
// services the front-panel load/deposit/examine/run/stop switches.
// Every output is a register, so each response appears in the cycle after the
// edge that samples its cause. A fetch ack is therefore followed by the X-load
// cycle (wrx + xin_dbus), then the incp cycle, then decode.
module q2_control #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             run_sw,
  input  logic             stop_sw,
  input  logic             load_sw,
  input  logic             dep_sw,
  input  logic             exam_sw,
  input  logic [WIDTH-1:0] ir_in,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             mem_we,
  output logic             wra,
  output logic             rda,
  output logic             incp,
  output logic             rdp,
  output logic             wrx,
  output logic             rdx,
  output logic             wrs,
  output logic             dep,
  output logic             xin_zero,
  output logic             xin_shift,
  output logic             xin_p,
  output logic             xin_dbus,
  output logic             nwrp,
  output logic             nsw,
  output logic             running,
  output logic             halted
);

  typedef enum logic [3:0] {
    StStop,
    StDepWait,
    StExWait,
    StFetch,
    StFetchX,
    StDecode,
    StLdaWait,
    StStaWait,
    StBoundary
  } state_t;

  state_t     state_q;
  logic [2:0] opcode_q;
  logic       stop_pending_q;
  logic [4:0] sw_prev_q;

  logic run_edge, stop_edge, load_edge, dep_edge, exam_edge;

  // Only the opcode field is kept; the operand travels on the data bus to X.
  logic unused_operand;
  assign unused_operand = ^ir_in[WIDTH-4:0];

  // Rising-edge detection of the front-panel switch levels.
  always_comb begin
    run_edge  = run_sw  & ~sw_prev_q[4];
    stop_edge = stop_sw & ~sw_prev_q[3];
    load_edge = load_sw & ~sw_prev_q[2];
    dep_edge  = dep_sw  & ~sw_prev_q[1];
    exam_edge = exam_sw & ~sw_prev_q[0];
  end

  // Sequencer state and registered strobes; strobes default to idle each cycle
  // and are re-asserted only by the branch that needs them.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q        <= StStop;
      opcode_q       <= 3'd0;
      stop_pending_q <= 1'b0;
      sw_prev_q      <= {run_sw, stop_sw, load_sw, dep_sw, exam_sw};
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      wra            <= 1'b0;
      rda            <= 1'b0;
      incp           <= 1'b0;
      rdp            <= 1'b0;
      wrx            <= 1'b0;
      rdx            <= 1'b0;
      wrs            <= 1'b0;
      dep            <= 1'b0;
      xin_zero       <= 1'b0;
      xin_shift      <= 1'b0;
      xin_p          <= 1'b0;
      xin_dbus       <= 1'b0;
      nwrp           <= 1'b1;
      nsw            <= 1'b1;
      running        <= 1'b0;
      halted         <= 1'b0;
    end else begin
      sw_prev_q <= {run_sw, stop_sw, load_sw, dep_sw, exam_sw};
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      wra       <= 1'b0;
      rda       <= 1'b0;
      incp      <= 1'b0;
      rdp       <= 1'b0;
      wrx       <= 1'b0;
      rdx       <= 1'b0;
      wrs       <= 1'b0;
      dep       <= 1'b0;
      xin_zero  <= 1'b0;
      xin_shift <= 1'b0;
      xin_p     <= 1'b0;
      xin_dbus  <= 1'b0;
      nwrp      <= 1'b1;
      nsw       <= 1'b1;

      // A stop request never aborts an instruction; it is honoured at the boundary.
      if (stop_edge && running) stop_pending_q <= 1'b1;

      case (state_q)
        StStop: begin
          stop_pending_q <= 1'b0;
          if (load_edge) begin
            nsw  <= 1'b0;
            nwrp <= 1'b0;
          end else if (dep_edge) begin
            nsw     <= 1'b0;
            dep     <= 1'b1;
            rdp     <= 1'b1;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
            state_q <= StDepWait;
          end else if (exam_edge) begin
            rdp     <= 1'b1;
            mem_req <= 1'b1;
            state_q <= StExWait;
          end else if (run_edge && !stop_edge) begin
            rdp     <= 1'b1;
            mem_req <= 1'b1;
            running <= 1'b1;
            halted  <= 1'b0;
            state_q <= StFetch;
          end
        end
        StDepWait: begin
          if (mem_ack) begin
            incp    <= 1'b1;
            state_q <= StStop;
          end else begin
            nsw     <= 1'b0;
            dep     <= 1'b1;
            rdp     <= 1'b1;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
          end
        end
        StExWait: begin
          if (mem_ack) begin
            incp    <= 1'b1;
            state_q <= StStop;
          end else begin
            rdp     <= 1'b1;
            mem_req <= 1'b1;
          end
        end
        StFetch: begin
          if (mem_ack) begin
            opcode_q <= ir_in[WIDTH-1 -: 3];
            wrx      <= 1'b1;
            xin_dbus <= 1'b1;
            state_q  <= StFetchX;
          end else begin
            rdp     <= 1'b1;
            mem_req <= 1'b1;
          end
        end
        StFetchX: begin
          incp    <= 1'b1;
          state_q <= StDecode;
        end
        StDecode: begin
          state_q <= StBoundary;
          case (opcode_q)
            3'd0: begin
              rdx     <= 1'b1;
              mem_req <= 1'b1;
              state_q <= StLdaWait;
            end
            3'd1: begin
              rdx     <= 1'b1;
              rda     <= 1'b1;
              mem_req <= 1'b1;
              mem_we  <= 1'b1;
              state_q <= StStaWait;
            end
            3'd2: nwrp <= 1'b0;
            3'd3: nwrp <= ~zero;
            3'd4: begin
              wrx       <= 1'b1;
              xin_shift <= 1'b1;
            end
            3'd5: begin
              wrx   <= 1'b1;
              xin_p <= 1'b1;
            end
            3'd6: begin
              wrx      <= 1'b1;
              xin_zero <= 1'b1;
            end
            default: begin
              halted         <= 1'b1;
              running        <= 1'b0;
              stop_pending_q <= 1'b0;
              state_q        <= StStop;
            end
          endcase
        end
        StLdaWait: begin
          if (mem_ack) begin
            wra     <= 1'b1;
            state_q <= StBoundary;
          end else begin
            rdx     <= 1'b1;
            mem_req <= 1'b1;
          end
        end
        StStaWait: begin
          if (mem_ack) begin
            state_q <= StBoundary;
          end else begin
            rdx     <= 1'b1;
            rda     <= 1'b1;
            mem_req <= 1'b1;
            mem_we  <= 1'b1;
          end
        end
        StBoundary: begin
          if (stop_pending_q || stop_edge) begin
            running        <= 1'b0;
            stop_pending_q <= 1'b0;
            state_q        <= StStop;
          end else begin
            rdp     <= 1'b1;
            mem_req <= 1'b1;
            state_q <= StFetch;
          end
        end
        default: state_q <= StStop;
      endcase
    end
  end

endmodule

// File: tb/tb_q2_control.sv
// Directed bench for q2_control: front-panel operations, fetch/decode timing,
// JZ on both zero values, stop during STA, HLT and run/stop collision.
module tb_q2_control;

  logic        clk = 1'b0;
  logic        nrst;
  logic        run_sw, stop_sw, load_sw, dep_sw, exam_sw;
  logic [11:0] ir_in;
  logic        zero, mem_ack;
  logic        mem_req, mem_we, wra, rda, incp, rdp, wrx, rdx, wrs, dep;
  logic        xin_zero, xin_shift, xin_p, xin_dbus, nwrp, nsw, running, halted;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  // Bit positions of the observed output vector; active-low strobes are
  // given as "asserted" and inverted by exp_of.
  localparam logic [17:0] MREQ = 18'h1 << 17;
  localparam logic [17:0] MWE  = 18'h1 << 16;
  localparam logic [17:0] WRA  = 18'h1 << 15;
  localparam logic [17:0] RDA  = 18'h1 << 14;
  localparam logic [17:0] INCP = 18'h1 << 13;
  localparam logic [17:0] RDP  = 18'h1 << 12;
  localparam logic [17:0] WRX  = 18'h1 << 11;
  localparam logic [17:0] RDX  = 18'h1 << 10;
  localparam logic [17:0] WRS  = 18'h1 << 9;
  localparam logic [17:0] DEP  = 18'h1 << 8;
  localparam logic [17:0] XZ   = 18'h1 << 7;
  localparam logic [17:0] XS   = 18'h1 << 6;
  localparam logic [17:0] XP   = 18'h1 << 5;
  localparam logic [17:0] XD   = 18'h1 << 4;
  localparam logic [17:0] NWRP = 18'h1 << 3;
  localparam logic [17:0] NSW  = 18'h1 << 2;
  localparam logic [17:0] RUN  = 18'h1 << 1;
  localparam logic [17:0] HALT = 18'h1;

  logic [17:0] obs;
  assign obs = {mem_req, mem_we, wra, rda, incp, rdp, wrx, rdx, wrs, dep,
                xin_zero, xin_shift, xin_p, xin_dbus, nwrp, nsw, running, halted};

  q2_control #(.WIDTH(12)) dut (
    .clk(clk), .nrst(nrst),
    .run_sw(run_sw), .stop_sw(stop_sw), .load_sw(load_sw), .dep_sw(dep_sw),
    .exam_sw(exam_sw), .ir_in(ir_in), .zero(zero), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .wra(wra), .rda(rda), .incp(incp),
    .rdp(rdp), .wrx(wrx), .rdx(rdx), .wrs(wrs), .dep(dep),
    .xin_zero(xin_zero), .xin_shift(xin_shift), .xin_p(xin_p), .xin_dbus(xin_dbus),
    .nwrp(nwrp), .nsw(nsw), .running(running), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] exp_of(input logic [17:0] asserted);
    return asserted ^ (NWRP | NSW);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [17:0] asserted);
    logic [17:0] e;
    e = exp_of(asserted);
    n_total++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, e);
  endtask

  // Fetch the given word with an immediate ack; leaves the DUT in the incp cycle.
  task automatic fetch_word(input string tag, input logic [11:0] word);
    ir_in   = word;
    mem_ack = 1'b1;
    tick();
    check({tag, "_xload"}, WRX | XD | RUN);
    mem_ack = 1'b0;
    tick();
    check({tag, "_incp"}, INCP | RUN);
  endtask

  initial begin
    nrst = 1'b0; run_sw = 1'b0; stop_sw = 1'b0; load_sw = 1'b0; dep_sw = 1'b0;
    exam_sw = 1'b0; ir_in = '0; zero = 1'b0; mem_ack = 1'b0;
    tick(); tick();
    check("reset", '0);
    nrst = 1'b1;
    tick();
    check("idle", '0);

    // Stray ack in STOP is ignored.
    mem_ack = 1'b1;
    tick();
    check("stray_ack", '0);
    mem_ack = 1'b0;

    // Load, with dep in the same cycle (load has priority).
    load_sw = 1'b1; dep_sw = 1'b1;
    tick();
    check("load", NWRP | NSW);
    tick();
    check("load_end", '0);
    load_sw = 1'b0; dep_sw = 1'b0;
    tick();

    // Deposit: strobes held 4 cycles, ack in the 4th, then incp.
    dep_sw = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("dep_hold", NSW | DEP | RDP | MREQ | MWE);
    end
    mem_ack = 1'b1;
    tick();
    check("dep_incp", INCP);
    mem_ack = 1'b0; dep_sw = 1'b0;
    tick();
    check("dep_done", '0);

    // Examine.
    exam_sw = 1'b1;
    tick();
    check("exam_req", RDP | MREQ);
    mem_ack = 1'b1;
    tick();
    check("exam_incp", INCP);
    mem_ack = 1'b0; exam_sw = 1'b0;
    tick();
    check("exam_done", '0);

    // Reset in the middle of a fetch.
    run_sw = 1'b1;
    tick();
    check("fetch_req", RDP | MREQ | RUN);
    nrst = 1'b0;
    tick();
    check("reset_mid_fetch", '0);
    nrst = 1'b1;
    tick();
    check("reset_primed", '0);
    run_sw = 1'b0;
    tick();

    // Run; LDA fetched with ack two cycles after the request starts.
    ir_in = 12'o0123;
    run_sw = 1'b1;
    tick();
    check("run_fetch1", RDP | MREQ | RUN);
    run_sw = 1'b0;
    tick();
    check("run_fetch2", RDP | MREQ | RUN);
    tick();
    check("run_fetch3", RDP | MREQ | RUN);
    mem_ack = 1'b1;
    tick();
    check("lda_xload", WRX | XD | RUN);
    mem_ack = 1'b0;
    tick();
    check("lda_incp", INCP | RUN);
    tick();
    check("lda_rdx", RDX | MREQ | RUN);
    tick();
    check("lda_rdx_hold", RDX | MREQ | RUN);
    mem_ack = 1'b1;
    tick();
    check("lda_wra", WRA | RUN);
    mem_ack = 1'b0;
    tick();
    check("next_fetch", RDP | MREQ | RUN);

    // JZ, zero=0: no P write.
    zero = 1'b0;
    fetch_word("jz0", 12'o3456);
    tick();
    check("jz0_none", RUN);
    tick();
    check("jz0_fetch", RDP | MREQ | RUN);

    // JZ, zero=1: one nwrp cycle.
    zero = 1'b1;
    fetch_word("jz1", 12'o3000);
    tick();
    check("jz1_nwrp", NWRP | RUN);
    tick();
    check("jz1_fetch", RDP | MREQ | RUN);
    zero = 1'b0;

    // SHX.
    fetch_word("shx", 12'o4000);
    tick();
    check("shx_wrx", WRX | XS | RUN);
    tick();
    check("shx_fetch", RDP | MREQ | RUN);

    // STA with a stop request while waiting for its ack.
    fetch_word("sta", 12'o1077);
    tick();
    check("sta_req", RDX | RDA | MREQ | MWE | RUN);
    stop_sw = 1'b1;
    tick();
    check("sta_hold1", RDX | RDA | MREQ | MWE | RUN);
    stop_sw = 1'b0;
    tick();
    check("sta_hold2", RDX | RDA | MREQ | MWE | RUN);
    mem_ack = 1'b1;
    tick();
    check("sta_done", RUN);
    mem_ack = 1'b0;
    tick();
    check("stopped", '0);
    tick();
    check("no_refetch", '0);

    // Run and stop edges together in STOP: stay stopped.
    run_sw = 1'b1; stop_sw = 1'b1;
    tick();
    check("run_stop_same", '0);
    run_sw = 1'b0; stop_sw = 1'b0;
    tick();

    // HLT, then a fresh run clears halted.
    run_sw = 1'b1;
    tick();
    check("hlt_fetch", RDP | MREQ | RUN);
    run_sw = 1'b0;
    fetch_word("hlt", 12'o7000);
    tick();
    check("halted", HALT);
    tick();
    check("halted_hold", HALT);
    run_sw = 1'b1;
    tick();
    check("rerun", RDP | MREQ | RUN);
    run_sw = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
